// File: rtl/voice_allocator_pkg.sv
// Shared types for the voice allocator.
// Event kinds and per-voice lifecycle states.
package conFFTi;

  typedef enum logic {
    NOTE_OFF = 1'b0,
    NOTE_ON  = 1'b1
  } note_en_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    SUSTAINED = 2'd2
  } voice_state_t;

endpackage

// File: rtl/voice_allocator_lru_oldest.sv
// Picks the voice holding the highest LRU rank.
// Ranks are a permutation, so exactly one voice matches.
module lru_oldest #(
  parameter int VOICES = 8,
  parameter int RW     = 3
) (
  input  logic [VOICES-1:0][RW-1:0] rank,
  output logic [RW-1:0]             oldest
);

  // scan for the voice whose rank is VOICES-1
  always_comb begin
    oldest = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (rank[i] == RW'(VOICES - 1)) oldest = RW'(i);
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator with sustain and LRU stealing.
// One note event per cycle; all outputs are registered.
import conFFTi::*;

module voice_allocator #(
  parameter int VOICES = 8,
  parameter int NOTE_W = 7,
  parameter int VEL_W  = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           input_en,
  input  note_en_t                       note_in_en,
  input  logic [NOTE_W-1:0]              note_in,
  input  logic [VEL_W-1:0]               velocity_in,
  input  logic                           sustain_in,
  input  logic                           steal_en,
  output logic [VOICES-1:0]              voice_en,
  output logic [VOICES-1:0][NOTE_W-1:0]  voice_note,
  output logic [VOICES-1:0][VEL_W-1:0]   voice_velocity,
  output logic [VOICES-1:0]              voice_trigger,
  output logic [VOICES-1:0]              voice_release,
  output logic                           dropped
);

  localparam int RW = $clog2(VOICES);

  voice_state_t                  st_q [VOICES];
  voice_state_t                  st_d [VOICES];
  logic [VOICES-1:0][NOTE_W-1:0] note_d;
  logic [VOICES-1:0][VEL_W-1:0]  vel_d;
  logic [VOICES-1:0][RW-1:0]     rank_q, rank_d;
  logic [VOICES-1:0]             en_d, trig_d, rel_d;
  logic                          drop_d, sus_q, sus_fall;
  logic                          hit, has_idle, alloc;
  logic [RW-1:0]                 hit_idx, idle_idx;
  logic [RW-1:0]                 old_idx, sel, sel_rank;

  lru_oldest #(
    .VOICES (VOICES),
    .RW     (RW)
  ) u_lru (
    .rank   (rank_q),
    .oldest (old_idx)
  );

  assign sus_fall = sus_q & ~sustain_in;

  // sustain release first, then evaluate the event on that state
  always_comb begin
    st_d     = st_q;
    note_d   = voice_note;
    vel_d    = voice_velocity;
    rank_d   = rank_q;
    trig_d   = '0;
    rel_d    = '0;
    drop_d   = 1'b0;
    hit      = 1'b0;
    hit_idx  = '0;
    has_idle = 1'b0;
    idle_idx = '0;
    alloc    = 1'b0;
    sel      = '0;
    sel_rank = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (sus_fall && st_d[i] == SUSTAINED) begin
        st_d[i]   = IDLE;
        note_d[i] = '0;
        vel_d[i]  = '0;
        rel_d[i]  = 1'b1;
      end
    end
    for (int i = 0; i < VOICES; i++) begin
      if (!hit && st_d[i] != IDLE && note_d[i] == note_in) begin
        hit     = 1'b1;
        hit_idx = RW'(i);
      end
      if (!has_idle && st_d[i] == IDLE) begin
        has_idle = 1'b1;
        idle_idx = RW'(i);
      end
    end
    if (input_en && note_in_en == NOTE_ON) begin
      if (hit) begin
        alloc = 1'b1;
        sel   = hit_idx;
      end else if (has_idle) begin
        alloc = 1'b1;
        sel   = idle_idx;
      end else if (steal_en) begin
        alloc = 1'b1;
        sel   = old_idx;
      end else begin
        drop_d = 1'b1;
      end
    end
    if (input_en && note_in_en == NOTE_OFF && hit) begin
      for (int i = 0; i < VOICES; i++) begin
        if (RW'(i) == hit_idx && st_d[i] == ACTIVE) begin
          if (sustain_in) begin
            st_d[i] = SUSTAINED;
          end else begin
            st_d[i]   = IDLE;
            note_d[i] = '0;
            vel_d[i]  = '0;
            rel_d[i]  = 1'b1;
          end
        end
      end
    end
    if (alloc) begin
      for (int i = 0; i < VOICES; i++) begin
        if (RW'(i) == sel) sel_rank = rank_q[i];
      end
      for (int i = 0; i < VOICES; i++) begin
        if (RW'(i) == sel) begin
          rank_d[i] = '0;
          st_d[i]   = ACTIVE;
          note_d[i] = note_in;
          vel_d[i]  = velocity_in;
          trig_d[i] = 1'b1;
        end else if (rank_q[i] < sel_rank) begin
          rank_d[i] = rank_q[i] + RW'(1);
        end
      end
    end
    for (int i = 0; i < VOICES; i++) begin
      en_d[i] = (st_d[i] != IDLE);
    end
  end

  // register voice state, ranks and all outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < VOICES; i++) begin
        st_q[i]   <= IDLE;
        rank_q[i] <= RW'(i);
      end
      sus_q          <= 1'b0;
      voice_en       <= '0;
      voice_note     <= '0;
      voice_velocity <= '0;
      voice_trigger  <= '0;
      voice_release  <= '0;
      dropped        <= 1'b0;
    end else begin
      st_q           <= st_d;
      rank_q         <= rank_d;
      sus_q          <= sustain_in;
      voice_en       <= en_d;
      voice_note     <= note_d;
      voice_velocity <= vel_d;
      voice_trigger  <= trig_d;
      voice_release  <= rel_d;
      dropped        <= drop_d;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Randomised and directed bench for voice_allocator.
// A queue-based age model predicts every output each cycle.
import conFFTi::*;

module tb_voice_allocator;

  localparam int V  = 8;
  localparam int NW = 7;
  localparam int VW = 7;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   input_en = 1'b0;
  note_en_t               note_in_en = NOTE_OFF;
  logic [NW-1:0]          note_in = '0;
  logic [VW-1:0]          velocity_in = '0;
  logic                   sustain_in = 1'b0;
  logic                   steal_en = 1'b1;
  logic [V-1:0]           voice_en;
  logic [V-1:0][NW-1:0]   voice_note;
  logic [V-1:0][VW-1:0]   voice_velocity;
  logic [V-1:0]           voice_trigger;
  logic [V-1:0]           voice_release;
  logic                   dropped;

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  voice_allocator #(
    .VOICES (V),
    .NOTE_W (NW),
    .VEL_W  (VW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .input_en       (input_en),
    .note_in_en     (note_in_en),
    .note_in        (note_in),
    .velocity_in    (velocity_in),
    .sustain_in     (sustain_in),
    .steal_en       (steal_en),
    .voice_en       (voice_en),
    .voice_note     (voice_note),
    .voice_velocity (voice_velocity),
    .voice_trigger  (voice_trigger),
    .voice_release  (voice_release),
    .dropped        (dropped)
  );

  always #5 clk = ~clk;

  // model: 0 idle, 1 active, 2 sustained; age queue front = newest
  int         ms [V];
  int         mn [V];
  int         mv [V];
  int         age [$];
  bit         msus;
  logic [V-1:0] etrig, erel;
  bit         edrop;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  function automatic void mreset();
    age = {};
    for (int i = 0; i < V; i++) begin
      ms[i] = 0; mn[i] = 0; mv[i] = 0;
      age.push_back(i);
    end
    msus = 0; etrig = '0; erel = '0; edrop = 0;
  endfunction

  function automatic void mclear(input int i);
    ms[i] = 0; mn[i] = 0; mv[i] = 0; erel[i] = 1'b1;
  endfunction

  function automatic void mtouch(input int i);
    for (int k = 0; k < age.size(); k++) begin
      if (age[k] == i) begin
        age.delete(k);
        break;
      end
    end
    age.push_front(i);
  endfunction

  function automatic void mstep();
    int m, sel;
    etrig = '0; erel = '0; edrop = 0;
    if (msus && !sustain_in) begin
      for (int i = 0; i < V; i++) if (ms[i] == 2) mclear(i);
    end
    msus = sustain_in;
    if (!input_en) return;
    m = -1;
    for (int i = V - 1; i >= 0; i--)
      if (ms[i] != 0 && mn[i] == int'(note_in)) m = i;
    if (note_in_en == NOTE_ON) begin
      sel = m;
      if (sel < 0) for (int i = V - 1; i >= 0; i--) if (ms[i] == 0) sel = i;
      if (sel < 0 && steal_en) sel = age[age.size() - 1];
      if (sel < 0) begin
        edrop = 1;
      end else begin
        ms[sel] = 1; mn[sel] = int'(note_in); mv[sel] = int'(velocity_in);
        etrig[sel] = 1'b1;
        mtouch(sel);
      end
    end else if (m >= 0 && ms[m] == 1) begin
      if (sustain_in) ms[m] = 2;
      else mclear(m);
    end
  endfunction

  always @(posedge clk) begin
    if (reset) mreset();
    else mstep();
  end

  // compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (chk_on && !reset) begin
      logic [V-1:0] een;
      logic [V-1:0][NW-1:0] enote;
      logic [V-1:0][VW-1:0] evel;
      for (int i = 0; i < V; i++) begin
        een[i] = (ms[i] != 0);
        enote[i] = NW'(mn[i]);
        evel[i] = VW'(mv[i]);
      end
      chk("cyc_en", 64'(voice_en), 64'(een));
      chk("cyc_note", 64'(voice_note), 64'(enote));
      chk("cyc_vel", 64'(voice_velocity), 64'(evel));
      chk("cyc_trig", 64'(voice_trigger), 64'(etrig));
      chk("cyc_rel", 64'(voice_release), 64'(erel));
      chk("cyc_drop", 64'(dropped), 64'(edrop));
    end
  end

  task automatic ev(input bit ie, input note_en_t en, input int n,
                    input int v);
    input_en = ie;
    note_in_en = en;
    note_in = NW'(n);
    velocity_in = VW'(v);
    @(posedge clk);
    @(negedge clk);
    input_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    input_en = 1'b0;
    sustain_in = 1'b0;
    steal_en = 1'b1;
    #1;
    chk("rst_en", 64'(voice_en), 64'h0);
    chk("rst_note", 64'(voice_note), 64'h0);
    chk("rst_rel", 64'(voice_release), 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < V; i++) ev(1, NOTE_ON, 60 + i, 10 + i);
  endtask

  initial begin
    mreset();
    repeat (2) @(negedge clk);
    chk_on = 1;
    do_reset();

    ev(1, NOTE_ON, 60, 100);
    chk("on60_note", 64'(voice_note[0]), 64'd60);
    chk("on60_vel", 64'(voice_velocity[0]), 64'd100);
    chk("on60_trig", 64'(voice_trigger), 64'h01);
    chk("on60_en", 64'(voice_en), 64'h01);
    ev(0, NOTE_OFF, 0, 0);
    chk("on60_trig_once", 64'(voice_trigger), 64'h00);

    do_reset();
    fill();
    chk("fill_en", 64'(voice_en), 64'hff);
    steal_en = 1'b1;
    ev(1, NOTE_ON, 70, 33);
    chk("steal_note", 64'(voice_note[0]), 64'd70);
    chk("steal_trig", 64'(voice_trigger), 64'h01);
    chk("steal_norel", 64'(voice_release), 64'h00);
    ev(1, NOTE_ON, 71, 34);
    chk("steal2_note", 64'(voice_note[1]), 64'd71);
    chk("steal2_trig", 64'(voice_trigger), 64'h02);

    do_reset();
    fill();
    steal_en = 1'b0;
    ev(1, NOTE_ON, 70, 33);
    chk("drop_pulse", 64'(dropped), 64'd1);
    chk("drop_note0", 64'(voice_note[0]), 64'd60);
    chk("drop_trig", 64'(voice_trigger), 64'h00);
    chk("drop_en", 64'(voice_en), 64'hff);

    do_reset();
    sustain_in = 1'b1;
    ev(1, NOTE_ON, 60, 20);
    ev(1, NOTE_OFF, 60, 0);
    chk("sus_held", 64'(voice_en), 64'h01);
    chk("sus_norel", 64'(voice_release), 64'h00);
    sustain_in = 1'b0;
    ev(0, NOTE_OFF, 0, 0);
    chk("sus_rel", 64'(voice_release), 64'h01);
    chk("sus_off", 64'(voice_en), 64'h00);
    chk("sus_clr", 64'(voice_note[0]), 64'd0);

    do_reset();
    ev(1, NOTE_ON, 60, 50);
    ev(1, NOTE_ON, 60, 90);
    chk("retrig_vel", 64'(voice_velocity[0]), 64'd90);
    chk("retrig_en", 64'(voice_en), 64'h01);
    chk("retrig_trig", 64'(voice_trigger), 64'h01);

    do_reset();
    sustain_in = 1'b1;
    fill();
    for (int i = 0; i < V; i++) ev(1, NOTE_OFF, 60 + i, 0);
    chk("allsus_en", 64'(voice_en), 64'hff);
    sustain_in = 1'b0;
    steal_en = 1'b0;
    ev(1, NOTE_ON, 72, 64);
    chk("relon_rel", 64'(voice_release), 64'hff);
    chk("relon_en", 64'(voice_en), 64'h01);
    chk("relon_note", 64'(voice_note[0]), 64'd72);
    chk("relon_drop", 64'(dropped), 64'd0);

    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 150) == 0) do_reset();
      if ($urandom_range(0, 7) == 0) sustain_in = ~sustain_in;
      steal_en = 1'($urandom_range(0, 1));
      ev($urandom_range(0, 3) != 0, note_en_t'($urandom_range(0, 1)),
         60 + $urandom_range(0, 13), $urandom_range(0, 127));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
